seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per input word.
REQ-002 Parameter PATTERN, default 4'b1011: 4-bit pattern to detect, oldest bit in PATTERN[3].
REQ-003 Parameter CNT_W, default 8: width of the detection counter and threshold.
REQ-004 CLK  input  1  clock; all state changes on posedge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input word offered.
REQ-007 in_data  input  WIDTH  word, serialized MSB first.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 clr  input  1  synchronous clear of count, irq and match history.
REQ-010 thresh  input  CNT_W  irq threshold; 0 disables irq.
REQ-011 busy  output  1  serialization in progress.
REQ-012 det  output  1  one-cycle pulse per pattern match.
REQ-013 det_count  output  CNT_W  matches since reset/clr.
REQ-014 irq  output  1  sticky threshold-reached flag.

Function
REQ-015 FSM states: IDLE and SHIFT.
REQ-016 in_ready = (state==IDLE) or (state==SHIFT and bitcnt==WIDTH-1).
REQ-017 Accept = in_valid and in_ready: load in_data into shift register, bitcnt=0, next state SHIFT.
REQ-018 SHIFT: one bit per cycle = shreg MSB; shreg shifts left; bitcnt increments; history = {history[2:0], bit}; fill counter increments, saturating at 4.
REQ-019 At the end of the SHIFT cycle with bitcnt==WIDTH-1: accept the next word with no bubble if in_valid; otherwise return to IDLE.
REQ-020 busy = (state==SHIFT).
REQ-021 History and fill persist across words and idle gaps, so matches spanning word boundaries are detected; overlapping matches all count.
REQ-022 A match is {history[2:0], bit}==PATTERN with fill>=3 (at least 4 bits seen since reset/clr).
REQ-023 det is registered: high for exactly the one cycle following the SHIFT cycle of the completing bit; det_count updates on the same edge.
REQ-024 irq sets on the edge det_count becomes >= thresh, with thresh!=0; it stays set until clr or RST.
REQ-025 clr clears det_count, irq, history and fill and suppresses det that cycle.
REQ-026 clr has priority over a simultaneous match.
REQ-027 clr does not abort serialization or affect shreg/bitcnt/state.
REQ-028 A word offered while in_ready=0 is held by the source; no data is dropped or duplicated.

Reset
REQ-029 RST forces state=IDLE, bitcnt=0, shreg=0, history=0, fill=0, det=0, det_count=0, irq=0.
REQ-030 While RST is high, in_ready=1 and busy=0.
REQ-031 RST mid-word abandons the word; the first post-reset accept starts cleanly.

Configuration
REQ-032 Macro DET_COUNT_SAT_EN defined: det_count saturates at all-ones.
REQ-033 Macro DET_COUNT_SAT_EN undefined: det_count wraps modulo 2^CNT_W; irq, if already set, stays set.

Verification
REQ-034 Send one word 0xB0 -> det pulses once, the cycle after bit index 3; det_count=1; busy high 8 cycles.
REQ-035 Send 0x5B -> det pulses after bit indices 4 and 7 (overlap); det_count=2.
REQ-036 Send 0x0A, then 0xC0 after a 3-cycle gap -> single det after bit index 1 of the second word (boundary-spanning match); det_count=1.
REQ-037 Hold in_valid=1 for 4 words -> in_ready high only in each last SHIFT cycle; busy continuous for 32 cycles; no bubble.
REQ-038 thresh=3; send 0x5B then 0xB0 -> irq rises with the third det and stays high; pulse clr coincident with a match -> det=0, det_count=0, irq=0.
REQ-039 CNT_W=2; send 5 matches (0x5B, 0x5B, 0xB0) -> det_count=3 with DET_COUNT_SAT_EN, 1 without.
REQ-040 Assert RST at bit index 4 of 0x5B -> all outputs return to reset values immediately; a subsequent 0xB0 yields det_count=1.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Serializes WIDTH-bit words MSB first and detects a 4-bit pattern in the bit stream.
// Optional macro DET_COUNT_SAT_EN: det_count saturates at all-ones instead of wrapping.
module seq_det_ctrl #(
  parameter int         WIDTH   = 8,
  parameter logic [3:0] PATTERN = 4'b1011,
  parameter int         CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  output logic             busy,
  output logic             det,
  output logic [CNT_W-1:0] det_count,
  output logic             irq
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [2:0]       history;
  logic [2:0]       fill;
  logic             last_bit;
  logic             cur_bit;
  logic             match;
  logic [CNT_W-1:0] cnt_next;

  assign last_bit = (bitcnt == LAST);
  assign in_ready = (state == IDLE) || ((state == SHIFT) && last_bit);
  assign busy     = (state == SHIFT);
  assign cur_bit  = shreg[WIDTH-1];
  // fill >= 3 means the three history bits plus cur_bit are all real stream bits
  assign match    = (state == SHIFT) && ({history, cur_bit} == PATTERN) && (fill >= 3'd3);

  always_comb begin
    cnt_next = det_count + CNT_W'(1);
`ifdef DET_COUNT_SAT_EN
    if (&det_count) cnt_next = det_count;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      history   <= '0;
      fill      <= '0;
      det       <= 1'b0;
      det_count <= '0;
      irq       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg  <= in_data;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            bitcnt <= '0;
            if (in_valid) begin
              shreg <= in_data;
            end else begin
              shreg <= shreg << 1;
              state <= IDLE;
            end
          end else begin
            shreg  <= shreg << 1;
            bitcnt <= bitcnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // clr only touches the match path; serialization keeps running
      if (clr) begin
        history   <= '0;
        fill      <= '0;
        det       <= 1'b0;
        det_count <= '0;
        irq       <= 1'b0;
      end else begin
        if (state == SHIFT) begin
          history <= {history[1:0], cur_bit};
          if (fill != 3'd4) fill <= fill + 3'd1;
        end
        det <= match;
        if (match) begin
          det_count <= cnt_next;
          if ((thresh != '0) && (cnt_next >= thresh)) irq <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: stimulus pushes expected det events, a monitor pops them.
module tb_seq_det_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clr = 1'b0;
  logic [7:0] thresh = 8'd0;
  logic [1:0] thresh2 = 2'd0;
  logic       in_ready, busy, det, irq;
  logic [7:0] det_count;
  logic       in_ready2, busy2, det2, irq2;
  logic [1:0] det_count2;

  seq_det_ctrl #(.WIDTH(8), .PATTERN(4'b1011), .CNT_W(8)) u_dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .clr(clr), .thresh(thresh), .busy(busy), .det(det), .det_count(det_count), .irq(irq));

  seq_det_ctrl #(.WIDTH(8), .PATTERN(4'b1011), .CNT_W(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .clr(clr), .thresh(thresh2), .busy(busy2), .det(det2), .det_count(det_count2), .irq(irq2));

  always #5 CLK = ~CLK;

  typedef struct {int idx; int cnt; int irq;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int sc = 0;
  int run = 0;
  int max_run = 0;
  int rdy_busy = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input int cnt, input int irq_e);
    exp_t e;
    e.idx = idx; e.cnt = cnt; e.irq = irq_e;
    exp_q.push_back(e);
  endtask

  // monitor: sc counts SHIFT cycles seen so far, so sc-1 is the bit that completed the match
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      sc = 0; run = 0; max_run = 0; rdy_busy = 0;
    end else begin
      if (det) begin
        if (exp_q.size() == 0) begin
          chk("det_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("det_bit_index", sc - 1, e.idx);
          chk("det_count_at_det", int'(det_count), e.cnt);
          chk("irq_at_det", int'(irq), e.irq);
        end
      end
      if (busy) begin
        sc++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (busy && in_ready) rdy_busy++;
    end
  end

  task automatic apply_reset();
    in_valid = 1'b0; clr = 1'b0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_word(input logic [7:0] d);
    int n;
    @(negedge CLK);
    in_valid = 1'b1; in_data = d;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge CLK); n++;
    end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 200) begin
      @(negedge CLK); n++;
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic end_test(input string name, input int cnt, input int bits);
    wait_idle();
    chk({name, "_missed_det"}, exp_q.size(), 0);
    chk({name, "_det_count"}, int'(det_count), cnt);
    chk({name, "_shift_cycles"}, sc, bits);
  endtask

  initial begin
    // reset values, including while RST is held high
    RST = 1'b1;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_det", int'(det), 0);
    chk("rst_det_count", int'(det_count), 0);
    chk("rst_irq", int'(irq), 0);
    apply_reset();

    // single word 0xB0: match ends at bit 3
    push_exp(3, 1, 0);
    send_word(8'hB0);
    end_test("b0", 1, 8);
    chk("b0_busy_run", max_run, 8);
    chk("b0_ready_in_shift", rdy_busy, 1);

    // 0x5B: overlapping matches at bits 4 and 7
    apply_reset();
    push_exp(4, 1, 0);
    push_exp(7, 2, 0);
    send_word(8'h5B);
    end_test("5b", 2, 8);

    // 0x0A, gap, 0xC0: match spans the word boundary, ends at bit 1 of word 2
    apply_reset();
    push_exp(9, 1, 0);
    send_word(8'h0A);
    wait_idle();
    repeat (3) @(negedge CLK);
    send_word(8'hC0);
    end_test("span", 1, 16);

    // four back-to-back words, no bubble
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(8 * i + 3, i + 1, 0);
    for (int i = 0; i < 4; i++) send_word(8'hB0);
    end_test("b2b", 4, 32);
    chk("b2b_busy_run", max_run, 32);
    chk("b2b_ready_in_shift", rdy_busy, 4);

    // threshold irq, then clr coincident with a match
    apply_reset();
    thresh = 8'd3;
    push_exp(4, 1, 0);
    push_exp(7, 2, 0);
    push_exp(11, 3, 1);
    send_word(8'h5B);
    send_word(8'hB0);
    wait_idle();
    chk("irq_sticky", int'(irq), 1);
    send_word(8'hB0);
    repeat (3) @(posedge CLK);
    #1 clr = 1'b1;
    @(posedge CLK);
    #1 clr = 1'b0;
    end_test("clr", 0, 24);
    chk("clr_irq", int'(irq), 0);
    thresh = 8'd0;

    // five matches into a 2-bit counter
    apply_reset();
    push_exp(4, 1, 0);
    push_exp(7, 2, 0);
    push_exp(12, 3, 0);
    push_exp(15, 4, 0);
    push_exp(19, 5, 0);
    send_word(8'h5B);
    send_word(8'h5B);
    send_word(8'hB0);
    end_test("cnt2", 5, 24);
`ifdef DET_COUNT_SAT_EN
    chk("cnt2_narrow_count", int'(det_count2), 3);
`else
    chk("cnt2_narrow_count", int'(det_count2), 1);
`endif

    // reset mid-word, then a clean word
    apply_reset();
    send_word(8'h5B);
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_det", int'(det), 0);
    chk("midrst_det_count", int'(det_count), 0);
    chk("midrst_irq", int'(irq), 0);
    apply_reset();
    push_exp(3, 1, 0);
    send_word(8'hB0);
    end_test("postrst", 1, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
